full_idct_transform: RTL and testbench

FULL_IDCT_TRANSFORM -- requirements
Module: full_idct_transform

---
 rtl/full_idct_transform.sv | 155 +++++++++++++++
 tb/tb_full_idct_transform.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/full_idct_transform.sv
// Sequential 8-point orthonormal inverse DCT: one multiply-accumulate per enabled
// cycle, 64 cycles per block, rounded and saturated to signed 8-bit samples.
module full_idct_transform #(
  parameter int COEF_W    = 12,
  parameter int FRAC_BITS = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] coef0,
  input  logic signed [COEF_W-1:0] coef1,
  input  logic signed [COEF_W-1:0] coef2,
  input  logic signed [COEF_W-1:0] coef3,
  input  logic signed [COEF_W-1:0] coef4,
  input  logic signed [COEF_W-1:0] coef5,
  input  logic signed [COEF_W-1:0] coef6,
  input  logic signed [COEF_W-1:0] coef7,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [7:0]        sample0,
  output logic signed [7:0]        sample1,
  output logic signed [7:0]        sample2,
  output logic signed [7:0]        sample3,
  output logic signed [7:0]        sample4,
  output logic signed [7:0]        sample5,
  output logic signed [7:0]        sample6,
  output logic signed [7:0]        sample7,
  output logic                     busy
);

  localparam int CONST_W = 14;
  localparam int PROD_W  = COEF_W + CONST_W;
  localparam int ACC_W   = PROD_W + 3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

  logic [1:0]                state;
  logic [2:0]                n;
  logic [2:0]                k;
  logic signed [ACC_W-1:0]   acc;
  logic signed [COEF_W-1:0]  x_reg [8];
  logic signed [7:0]         s_reg [8];

  logic signed [CONST_W-1:0] c_val;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   rounded;
  logic signed [7:0]         sat_val;

  // C[n][k] folded onto the eight magnitudes of cos(j*pi/16), j = (2n+1)k mod 32;
  // the sign follows the quadrant of j. Magnitudes are scaled by 2^12.
  function automatic logic signed [CONST_W-1:0] cos_coef(input logic [2:0] nn,
                                                          input logic [2:0] kk);
    logic [6:0] m;
    logic [4:0] j;
    logic [2:0] idx;
    logic signed [CONST_W-1:0] mag;
    m   = 7'({nn, 1'b1}) * 7'(kk);
    j   = m[4:0];
    idx = j[3] ? 3'(4'd8 - {1'b0, j[2:0]}) : j[2:0];
    case (idx)
      3'd1:    mag = 14'sd2009;
      3'd2:    mag = 14'sd1892;
      3'd3:    mag = 14'sd1703;
      3'd4:    mag = 14'sd1448;
      3'd5:    mag = 14'sd1138;
      3'd6:    mag = 14'sd784;
      3'd7:    mag = 14'sd400;
      default: mag = 14'sd0;
    endcase
    if (kk == 3'd0) return 14'sd1448;
    return (j[4] ^ j[3]) ? -mag : mag;
  endfunction

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    c_val   = cos_coef(n, k);
    prod    = PROD_W'(x_reg[k]) * PROD_W'(c_val);
    sum     = acc + ACC_W'(prod);
    rounded = (sum + HALF) >>> FRAC_BITS;
    if (rounded > SAT_MAX)      sat_val = 8'sd127;
    else if (rounded < SAT_MIN) sat_val = -8'sd128;
    else                        sat_val = rounded[7:0];
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      k     <= '0;
      acc   <= '0;
      for (int i = 0; i < 8; i++) begin
        x_reg[i] <= '0;
        s_reg[i] <= '0;
      end
    end else if (en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg[0] <= coef0;
            x_reg[1] <= coef1;
            x_reg[2] <= coef2;
            x_reg[3] <= coef3;
            x_reg[4] <= coef4;
            x_reg[5] <= coef5;
            x_reg[6] <= coef6;
            x_reg[7] <= coef7;
            acc      <= '0;
            n        <= '0;
            k        <= '0;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          k <= k + 3'd1;
          if (k == 3'd7) begin
            s_reg[n] <= sat_val;
            acc      <= '0;
            n        <= n + 3'd1;
            if (n == 3'd7) state <= DONE;
          end else begin
            acc <= sum;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign sample0 = s_reg[0];
  assign sample1 = s_reg[1];
  assign sample2 = s_reg[2];
  assign sample3 = s_reg[3];
  assign sample4 = s_reg[4];
  assign sample5 = s_reg[5];
  assign sample6 = s_reg[6];
  assign sample7 = s_reg[7];

endmodule

// File: tb/tb_full_idct_transform.sv
// Bench for full_idct_transform: directed and random blocks checked against an
// integer model built from a cosine table computed with real arithmetic.
module tb_full_idct_transform;

  localparam int COEF_W    = 12;
  localparam int FRAC_BITS = 12;
  localparam real PI       = 3.14159265358979323846;

  logic clk;
  logic rst;
  logic en;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic signed [COEF_W-1:0] c_in [8];
  logic signed [7:0]        s_out [8];

  int errors = 0;
  int checks = 0;

  int  ctab [8][8];
  logic signed [COEF_W-1:0] blk [8];
  int  exp_s [8];
  real flt_s [8];

  full_idct_transform #(.COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .coef0(c_in[0]), .coef1(c_in[1]), .coef2(c_in[2]), .coef3(c_in[3]),
    .coef4(c_in[4]), .coef5(c_in[5]), .coef6(c_in[6]), .coef7(c_in[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .sample0(s_out[0]), .sample1(s_out[1]), .sample2(s_out[2]), .sample3(s_out[3]),
    .sample4(s_out[4]), .sample5(s_out[5]), .sample6(s_out[6]), .sample7(s_out[7]),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_table();
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++) begin
        real ck, v;
        ck = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
        v  = ck * $cos((2 * n + 1) * k * PI / 16.0) * (2.0 ** FRAC_BITS);
        ctab[n][k] = $rtoi($floor(v + 0.5));
      end
  endtask

  // Integer reference (rounded constants, round-half-up, saturate) plus ideal real IDCT.
  task automatic model();
    for (int n = 0; n < 8; n++) begin
      longint s;
      real f;
      s = 0;
      f = 0.0;
      for (int k = 0; k < 8; k++) begin
        s += longint'(blk[k]) * longint'(ctab[n][k]);
        f += $itor(blk[k]) * ((k == 0) ? $sqrt(1.0 / 8.0) : 0.5) *
             $cos((2 * n + 1) * k * PI / 16.0);
      end
      s = (s + (64'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      exp_s[n] = int'(s);
      if (f > 127.0) f = 127.0;
      if (f < -128.0) f = -128.0;
      flt_s[n] = f;
    end
  endtask

  task automatic scramble_inputs();
    in_valid = 1'($urandom);
    for (int i = 0; i < 8; i++) c_in[i] = COEF_W'($urandom);
  endtask

  // Feeds blk, optionally stalls en, holds in DONE, then completes the handshake.
  task automatic run_block(input string name, input int stall_at, input int stall_len,
                           input int hold, input bit flt_chk);
    int g, lat;
    model();
    g = 0;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    check({name, "_ready_pre"}, in_ready, 1);
    for (int i = 0; i < 8; i++) c_in[i] = blk[i];
    in_valid = 1'b1;
    tick();
    check({name, "_busy"}, busy, 1);
    check({name, "_in_ready_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 300) begin
      if (lat == stall_at) begin
        en = 1'b0;
        repeat (stall_len) begin
          scramble_inputs();
          tick();
          lat++;
        end
        en = 1'b1;
      end
      scramble_inputs();
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, lat, 64 + ((stall_at >= 0) ? stall_len : 0));
    for (int i = 0; i < 8; i++) check($sformatf("%s_s%0d", name, i), s_out[i], exp_s[i]);
    if (flt_chk)
      for (int i = 0; i < 8; i++) begin
        real d;
        d = $itor(s_out[i]) - flt_s[i];
        check($sformatf("%s_float%0d", name, i), (d <= 1.0 && d >= -1.0), 1);
      end
    out_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      scramble_inputs();
      tick();
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_ready"}, in_ready, 0);
    end
    if (hold > 0)
      for (int i = 0; i < 8; i++) check($sformatf("%s_hold_s%0d", name, i), s_out[i], exp_s[i]);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({name, "_ready_at_hs"}, in_ready, 0);
    tick();
    check({name, "_valid_drop"}, out_valid, 0);
    check({name, "_ready_back"}, in_ready, 1);
    check({name, "_persist_s0"}, s_out[0], exp_s[0]);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) c_in[i] = '0;
    build_table();
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_s%0d", i), s_out[i], 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) blk[i] = '0;
    run_block("zero", -1, 0, 0, 1'b0);

    blk[0] = 12'sd100;
    run_block("dc100", -1, 0, 0, 1'b1);
    check("dc100_anchor_s3", s_out[3], 35);

    blk[0] = 12'sd362;
    run_block("dc362", -1, 0, 0, 1'b0);
    check("dc362_anchor_s5", s_out[5], 127);

    blk[0] = -12'sd362;
    run_block("dcm362", -1, 0, 0, 1'b0);
    check("dcm362_anchor_s1", s_out[1], -128);

    blk[0] = '0;
    blk[1] = 12'sd64;
    run_block("ac1", -1, 0, 0, 1'b1);
    check("ac1_anchor_s0", s_out[0], 31);
    check("ac1_anchor_s7", s_out[7], -31);

    for (int i = 0; i < 8; i++) blk[i] = COEF_W'(int'($urandom_range(0, 400)) - 200);
    run_block("hold10", -1, 0, 10, 1'b1);

    for (int i = 0; i < 8; i++) blk[i] = COEF_W'(int'($urandom_range(0, 400)) - 200);
    run_block("stall5", 20, 5, 0, 1'b1);

    // Abort a block with reset at compute cycle 30.
    for (int i = 0; i < 8; i++) c_in[i] = COEF_W'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 8; i++) check($sformatf("abort_s%0d", i), s_out[i], 0);
    for (int i = 0; i < 8; i++) blk[i] = COEF_W'(int'($urandom_range(0, 400)) - 200);
    run_block("post_rst", -1, 0, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) blk[i] = COEF_W'($urandom);
      run_block($sformatf("rnd%0d", r), -1, 0, r % 3, 1'b0);
    end
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) blk[i] = COEF_W'(int'($urandom_range(0, 160)) - 80);
      run_block($sformatf("rsm%0d", r), r * 11, r + 1, 1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
